fir_datapath_exec: RTL

- Execution end of the FIR operation interface. Accepts one op/src1/src2/dest command per strobe from the FIR controller and executes it on a 16-entry register file.
- Returns `busy`, `op_done`, an overflow flag and the accumulator (R0) value to the controller and the output stage.
- Single-cycle ops: copy, load, add, subtract. Multi-cycle op: iterative shift-add fixed-point multiply.

---
 rtl/fir_op_if.sv | 26 ++
 rtl/fir_datapath_exec.sv | 139 +++++++++++++
 2 files changed

// File: rtl/fir_op_if.sv
// Command/status bundle between the FIR controller and the execution datapath.
// The controller drives commands through master; the datapath returns status through slave.
interface fir_op_if #(
    parameter int WIDTH = 16
) ();
    logic             op_valid;
    logic [2:0]       op;
    logic [3:0]       src1;
    logic [3:0]       src2;
    logic [3:0]       dest;
    logic [WIDTH-1:0] ext_data;
    logic             busy;
    logic             op_done;
    logic             overflow;
    logic [WIDTH-1:0] fir_out;

    modport master (
        output op_valid, op, src1, src2, dest, ext_data,
        input  busy, op_done, overflow, fir_out
    );

    modport slave (
        input  op_valid, op, src1, src2, dest, ext_data,
        output busy, op_done, overflow, fir_out
    );
endinterface

// File: rtl/fir_datapath_exec.sv
// FIR execution datapath: 16-entry register file with single-cycle copy/load/add/sub
// and an iterative shift-add Q1.15 multiply that holds busy while it runs.
module fir_datapath_exec #(
    parameter int WIDTH     = 16,
    parameter int NUM_REGS  = 16,
    parameter int FRAC_BITS = 15
) (
    input logic   clk,
    input logic   rst,
    fir_op_if.slave bus
);
    localparam int CNT_W = $clog2(WIDTH);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] MUL_RUN = 1'b1;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_COPY  = 3'b001;
    localparam logic [2:0] OP_LDSMP = 3'b010;
    localparam logic [2:0] OP_LDCOE = 3'b011;
    localparam logic [2:0] OP_ADD   = 3'b100;
    localparam logic [2:0] OP_SUB   = 3'b101;
    localparam logic [2:0] OP_MUL   = 3'b110;

    logic [WIDTH-1:0]   regs [NUM_REGS];
    logic [0:0]         state;
    logic [WIDTH-1:0]   mul_a;
    logic [WIDTH-1:0]   mul_b;
    logic [3:0]         mul_dest;
    logic [2*WIDTH-1:0] acc;
    logic [CNT_W-1:0]   bit_cnt;
    logic               ovf_q;
    logic               done_q;

    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [WIDTH:0]     sum;
    logic [WIDTH:0]     diff;
    logic [2*WIDTH-1:0] partial;
    logic [2*WIDTH-1:0] acc_next;
    logic               last_iter;

    // Product bits [FRAC_BITS+WIDTH-1:FRAC_BITS] form the Q-scaled result.
    function automatic logic [WIDTH-1:0] scale_product(input logic [2*WIDTH-1:0] p);
        logic [2*WIDTH-1:0] s;
        s = p >> FRAC_BITS;
        return s[WIDTH-1:0];
    endfunction

    function automatic logic product_overflow(input logic [2*WIDTH-1:0] p);
        return (p >> (FRAC_BITS + WIDTH)) != '0;
    endfunction

    always_comb begin
        opa       = regs[bus.src1];
        opb       = regs[bus.src2];
        sum       = {1'b0, opa} + {1'b0, opb};
        diff      = {1'b0, opa} - {1'b0, opb};
        partial   = mul_b[bit_cnt] ? ({{WIDTH{1'b0}}, mul_a} << bit_cnt) : '0;
        acc_next  = acc + partial;
        last_iter = (bit_cnt == CNT_W'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
            state    <= IDLE;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_dest <= '0;
            acc      <= '0;
            bit_cnt  <= '0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.op_valid) begin
                        case (bus.op)
                            OP_COPY: begin
                                regs[bus.dest] <= opa;
                                done_q         <= 1'b1;
                            end
                            OP_LDSMP: begin
                                regs[bus.dest] <= bus.ext_data;
                                ovf_q          <= 1'b0;
                                done_q         <= 1'b1;
                            end
                            OP_LDCOE: begin
                                regs[bus.dest] <= bus.ext_data;
                                done_q         <= 1'b1;
                            end
                            OP_ADD: begin
                                regs[bus.dest] <= sum[WIDTH-1:0];
                                ovf_q          <= sum[WIDTH];
                                done_q         <= 1'b1;
                            end
                            OP_SUB: begin
                                // Top bit of the widened difference is the borrow.
                                regs[bus.dest] <= diff[WIDTH-1:0];
                                ovf_q          <= diff[WIDTH];
                                done_q         <= 1'b1;
                            end
                            OP_MUL: begin
                                mul_a    <= opa;
                                mul_b    <= opb;
                                mul_dest <= bus.dest;
                                acc      <= '0;
                                bit_cnt  <= '0;
                                state    <= MUL_RUN;
                            end
                            default: done_q <= 1'b1;
                        endcase
                    end
                end
                MUL_RUN: begin
                    acc     <= acc_next;
                    bit_cnt <= bit_cnt + CNT_W'(1);
                    if (last_iter) begin
                        regs[mul_dest] <= scale_product(acc_next);
                        ovf_q          <= product_overflow(acc_next);
                        done_q         <= 1'b1;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = (state == MUL_RUN);
    assign bus.op_done  = done_q;
    assign bus.overflow = ovf_q;
    assign bus.fir_out  = regs[0];

    logic unused_op_nop;
    assign unused_op_nop = ^OP_NOP;
endmodule
